bus_cmd_master: RTL and testbench

- Upstream driver of the bus command interface. Accepts read/write requests from a valid/ready request port and buffers them in a small FIFO.
- Issues each request as a single-cycle bus command on bus_cmd_valid/bus_op/bus_addr/bus_wr_data.
- For reads, captures bus_rd_data and returns it on a response port.
- Sits between sequencer-side or CPU-side logic and the bus slave register bank.

---
 rtl/bus_cmd_master.sv | 196 +++++++++++++++++++
 tb/tb_bus_cmd_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cmd_master.sv
// bus_cmd_master: upstream bus command driver.
// Requests arrive on a valid/ready port and are buffered in a small FIFO. Each
// request goes out as a single-cycle bus command. Read data is captured the
// cycle after a read command and returned as a one-cycle response pulse.
module bus_cmd_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_cmd_valid,
  output logic                  bus_op,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wr_data,
  input  logic [DATA_WIDTH-1:0] bus_rd_data,
  output logic                  busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic                  fifo_op_r   [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_r [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;
  logic                  req_ready_r;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;

  // FSM and command register
  state_t                state_r;
  state_t                state_next_s;
  logic                  cmd_op_r;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  logic [DATA_WIDTH-1:0] cmd_data_r;

  // Response registers
  logic                  rsp_valid_r;
  logic [ADDR_WIDTH-1:0] rsp_addr_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;

  // req_ready is registered, so it reflects fullness before any same-cycle pop.
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s       = req_valid && req_ready_r;

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO payload storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_op_r[wr_ptr_r]   <= req_op;
      fifo_addr_r[wr_ptr_r] <= req_addr;
      fifo_data_r[wr_ptr_r] <= req_wdata;
    end
  end

  // FIFO pointers (wrap naturally since DEPTH is a power of two), count and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r     <= count_next_s;
      req_ready_r <= (count_next_s != CNT_FULL);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and FIFO pop decision.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!cmd_op_r) begin
          state_next_s = ST_WAIT_RD;
        end else if (!fifo_empty_s) begin
          // Streaming writes: reload the command register without a gap.
          pop_s        = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT_RD: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Command register loads the FIFO head on every pop; read data is zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_op_r   <= 1'b0;
      cmd_addr_r <= {ADDR_WIDTH{1'b0}};
      cmd_data_r <= {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      cmd_op_r   <= fifo_op_r[rd_ptr_r];
      cmd_addr_r <= fifo_addr_r[rd_ptr_r];
      cmd_data_r <= fifo_op_r[rd_ptr_r] ? fifo_data_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    end else begin
      cmd_op_r   <= cmd_op_r;
      cmd_addr_r <= cmd_addr_r;
      cmd_data_r <= cmd_data_r;
    end
  end

  // Read capture: slave data is valid during WAIT_RD; pulse rsp_valid next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_addr_r  <= {ADDR_WIDTH{1'b0}};
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp_valid_r <= (state_r == ST_WAIT_RD);
      if (state_r == ST_WAIT_RD) begin
        rsp_addr_r  <= cmd_addr_r;
        rsp_rdata_r <= bus_rd_data;
      end else begin
        rsp_addr_r  <= rsp_addr_r;
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  // Bus fields are decoded from registers and held at zero outside the strobe.
  assign bus_cmd_valid = (state_r == ST_ISSUE);
  assign bus_op        = bus_cmd_valid && cmd_op_r;
  assign bus_addr      = bus_cmd_valid ? cmd_addr_r : {ADDR_WIDTH{1'b0}};
  assign bus_wr_data   = (bus_cmd_valid && cmd_op_r) ? cmd_data_r : {DATA_WIDTH{1'b0}};

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_addr  = rsp_addr_r;
  assign rsp_rdata = rsp_rdata_r;
  assign busy      = !fifo_empty_s || (state_r != ST_IDLE);

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed testbench for bus_cmd_master with a one-cycle-latency read slave.
module tb_bus_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_op = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        rsp_valid;
  logic [15:0] rsp_addr;
  logic [15:0] rsp_rdata;
  logic        bus_cmd_valid;
  logic        bus_op;
  logic [15:0] bus_addr;
  logic [15:0] bus_wr_data;
  logic [15:0] bus_rd_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bus_cmd_master #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .bus_cmd_valid(bus_cmd_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: read data for the address of the previous read command.
  function automatic logic [15:0] slave_val(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'h5A00);
  endfunction

  logic [15:0] rd_addr_q = 16'h0;
  always @(posedge clk) if (bus_cmd_valid && !bus_op) rd_addr_q <= bus_addr;
  assign bus_rd_data = slave_val(rd_addr_q);

  // Monitor: log commands, responses and req_ready low cycles.
  logic        m_op   [64];
  logic [15:0] m_addr [64];
  logic [15:0] m_data [64];
  int          m_cyc  [64];
  logic [15:0] r_addr [64];
  logic [15:0] r_data [64];
  int          r_cyc  [64];
  int ncmd = 0;
  int nrsp = 0;
  int ready_low_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus_cmd_valid && ncmd < 64) begin
        m_op[ncmd]   <= bus_op;
        m_addr[ncmd] <= bus_addr;
        m_data[ncmd] <= bus_wr_data;
        m_cyc[ncmd]  <= cyc;
        ncmd <= ncmd + 1;
      end
      if (rsp_valid && nrsp < 64) begin
        r_addr[nrsp] <= rsp_addr;
        r_data[nrsp] <= rsp_rdata;
        r_cyc[nrsp]  <= cyc;
        nrsp <= nrsp + 1;
      end
      if (!req_ready) ready_low_cnt <= ready_low_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic op, input logic [15:0] a, input logic [15:0] d);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin step(); n++; end
    checks++;
    if (!req_ready) begin
      errors++; $display("FAIL send_timeout addr=%h: req_ready stuck low, required 1", a);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    checks++;
    if (busy) begin errors++; $display("FAIL idle_timeout: busy=1, required 0"); end
    step(); step(); step();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (bus_cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got %b exp 0", bus_cmd_valid); end
    checks++; if (bus_addr !== 16'h0) begin errors++; $display("FAIL rst_bus_addr got %h exp 0", bus_addr); end
    checks++; if (rsp_addr !== 16'h0 || rsp_rdata !== 16'h0) begin errors++; $display("FAIL rst_rsp got %h/%h exp 0/0", rsp_addr, rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    rst = 1'b0;
    step();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst ready/busy got %b/%b exp 1/0", req_ready, busy); end
  endtask

  task automatic test_single_write();
    int rb = nrsp;
    req_valid = 1'b1; req_op = 1'b1; req_addr = 16'h0010; req_wdata = 16'hA5A5;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b exp 1", req_ready); end
    step();                                   // N+1
    req_valid = 1'b0;
    checks++; if (bus_cmd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL wr_n1 valid/busy got %b/%b exp 0/1", bus_cmd_valid, busy); end
    step();                                   // N+2
    checks++; if (bus_cmd_valid !== 1'b1) begin errors++; $display("FAIL wr_n2_valid got %b exp 1", bus_cmd_valid); end
    checks++; if (bus_op !== 1'b1 || bus_addr !== 16'h0010 || bus_wr_data !== 16'hA5A5) begin
      errors++; $display("FAIL wr_n2_fields got op=%b a=%h d=%h exp 1/0010/a5a5", bus_op, bus_addr, bus_wr_data); end
    step();                                   // N+3
    checks++; if (bus_cmd_valid !== 1'b0 || bus_addr !== 16'h0 || bus_wr_data !== 16'h0) begin
      errors++; $display("FAIL wr_n3_bus got v=%b a=%h d=%h exp 0/0/0", bus_cmd_valid, bus_addr, bus_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_n3_busy got %b exp 0", busy); end
    step(); step();
    checks++; if (nrsp !== rb) begin errors++; $display("FAIL wr_no_rsp got %0d rsp exp %0d", nrsp, rb); end
  endtask

  task automatic test_single_read();
    req_valid = 1'b1; req_op = 1'b0; req_addr = 16'h0020; req_wdata = 16'hFFFF;
    step();                                   // N+1
    req_valid = 1'b0;
    step();                                   // N+2
    checks++; if (bus_cmd_valid !== 1'b1 || bus_op !== 1'b0 || bus_addr !== 16'h0020 || bus_wr_data !== 16'h0) begin
      errors++; $display("FAIL rd_n2 got v=%b op=%b a=%h d=%h exp 1/0/0020/0000", bus_cmd_valid, bus_op, bus_addr, bus_wr_data); end
    step();                                   // N+3
    checks++; if (bus_cmd_valid !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rd_n3 got v=%b rsp=%b exp 0/0", bus_cmd_valid, rsp_valid); end
    step();                                   // N+4
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd_n4_rsp_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_addr !== 16'h0020 || rsp_rdata !== 16'h1234) begin
      errors++; $display("FAIL rd_n4_rsp got a=%h d=%h exp 0020/1234", rsp_addr, rsp_rdata); end
    step();                                   // N+5
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_n5_pulse got %b exp 0", rsp_valid); end
  endtask

  // Three leading reads stall the FSM long enough to fill all four entries.
  task automatic test_back_to_back();
    logic        ops [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] ads [8] = '{16'h0030, 16'h0031, 16'h0032, 16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0044};
    logic [15:0] dts [8] = '{16'hEEEE, 16'hEEEE, 16'hEEEE, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004};
    int base = ncmd;
    int rb   = nrsp;
    int rl   = ready_low_cnt;
    for (int i = 0; i < 8; i++) send(ops[i], ads[i], dts[i]);
    wait_idle();
    checks++; if (ready_low_cnt <= rl) begin errors++; $display("FAIL b2b_ready_drop got %0d low cycles exp >0", ready_low_cnt - rl); end
    checks++; if (ncmd - base !== 8) begin errors++; $display("FAIL b2b_cmd_count got %0d exp 8", ncmd - base); end
    checks++; if (nrsp - rb !== 3) begin errors++; $display("FAIL b2b_rsp_count got %0d exp 3", nrsp - rb); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m_op[base+i] !== ops[i] || m_addr[base+i] !== ads[i] || m_data[base+i] !== (ops[i] ? dts[i] : 16'h0)) begin
        errors++; $display("FAIL b2b_cmd%0d got op=%b a=%h d=%h exp op=%b a=%h", i, m_op[base+i], m_addr[base+i], m_data[base+i], ops[i], ads[i]);
      end
    end
    for (int i = 4; i < 8; i++) begin
      checks++;
      if (m_cyc[base+i] !== m_cyc[base+i-1] + 1) begin
        errors++; $display("FAIL b2b_consec%0d got cycle %0d exp %0d", i, m_cyc[base+i], m_cyc[base+i-1] + 1);
      end
    end
  endtask

  task automatic test_interleaved();
    logic        ops [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ads [4] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    int base = ncmd;
    int rb   = nrsp;
    for (int i = 0; i < 4; i++) send(ops[i], ads[i], 16'hD000 + 16'(i));
    wait_idle();
    checks++; if (ncmd - base !== 4) begin errors++; $display("FAIL il_cmd_count got %0d exp 4", ncmd - base); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_op[base+i] !== ops[i] || m_addr[base+i] !== ads[i]) begin
        errors++; $display("FAIL il_cmd%0d got op=%b a=%h exp op=%b a=%h", i, m_op[base+i], m_addr[base+i], ops[i], ads[i]);
      end
    end
    checks++; if (m_cyc[base+2] < m_cyc[base+1] + 3) begin
      errors++; $display("FAIL il_wait_rd_gap got cycle %0d exp >= %0d", m_cyc[base+2], m_cyc[base+1] + 3); end
    checks++; if (nrsp - rb !== 2) begin errors++; $display("FAIL il_rsp_count got %0d exp 2", nrsp - rb); end
    checks++; if (r_addr[rb] !== 16'h0002 || r_data[rb] !== 16'h5A02 || r_cyc[rb] !== m_cyc[base+1] + 2) begin
      errors++; $display("FAIL il_rsp0 got a=%h d=%h exp 0002/5a02", r_addr[rb], r_data[rb]); end
    checks++; if (r_addr[rb+1] !== 16'h0004 || r_data[rb+1] !== 16'h5A04 || r_cyc[rb+1] !== m_cyc[base+3] + 2) begin
      errors++; $display("FAIL il_rsp1 got a=%h d=%h exp 0004/5a04", r_addr[rb+1], r_data[rb+1]); end
  endtask

  task automatic test_reset_mid();
    int base = ncmd;
    int rb   = nrsp;
    send(1'b0, 16'h0050, 16'h0);
    send(1'b1, 16'h0060, 16'h6666);
    send(1'b1, 16'h0070, 16'h7777);         // now in WAIT_RD with two entries queued
    checks++; if (bus_cmd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rm_pre got v=%b busy=%b exp 0/1", bus_cmd_valid, busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || bus_cmd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rm_async got ready=%b rsp=%b v=%b busy=%b exp 1/0/0/0", req_ready, rsp_valid, bus_cmd_valid, busy); end
    checks++; if (rsp_addr !== 16'h0 || rsp_rdata !== 16'h0 || bus_op !== 1'b0 || bus_addr !== 16'h0 || bus_wr_data !== 16'h0) begin
      errors++; $display("FAIL rm_async_data got ra=%h rd=%h op=%b a=%h d=%h exp zeros", rsp_addr, rsp_rdata, bus_op, bus_addr, bus_wr_data); end
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (ncmd - base !== 1) begin errors++; $display("FAIL rm_no_issue got %0d cmds exp 1", ncmd - base); end
    checks++; if (nrsp !== rb) begin errors++; $display("FAIL rm_no_rsp got %0d rsp exp %0d", nrsp - rb, 0); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      int base = ncmd;
      int rl   = ready_low_cnt;
      for (int i = 0; i < 6; i++) send(i >= 3, 16'h0100 * 16'(r + 1) + 16'(i), 16'hC000 + 16'(r * 16 + i));
      wait_idle();
      checks++; if (ready_low_cnt <= rl) begin errors++; $display("FAIL wrap%0d_full got no ready drop exp drop", r); end
      checks++; if (ncmd - base !== 6) begin errors++; $display("FAIL wrap%0d_count got %0d exp 6", r, ncmd - base); end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (m_op[base+i] !== (i >= 3) || m_addr[base+i] !== 16'h0100 * 16'(r + 1) + 16'(i) ||
            m_data[base+i] !== ((i >= 3) ? 16'hC000 + 16'(r * 16 + i) : 16'h0)) begin
          errors++; $display("FAIL wrap%0d_cmd%0d got op=%b a=%h d=%h", r, i, m_op[base+i], m_addr[base+i], m_data[base+i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_interleaved();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
